// File: rtl/vc_ctrl_param.sv
// Input virtual-channel controller: routes each packet through RC -> VA -> ST and counts its flits.
// Optional feature: define VC_TIMEOUT_EN to add a switch-wait timeout that briefly drops req and pulses tmo_o.
module vc_ctrl_param #(
    parameter int NPORT   = 5,
    parameter int NVCH    = 2,
    parameter int PORTW   = 3,
    parameter int VCHW    = 1,
    parameter int CNTW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bvalid_i,
    input  logic [1:0]              btype_i,
    input  logic [PORTW-1:0]        port_i,
    input  logic [VCHW-1:0]         ovch_i,
    input  logic [NPORT*NVCH-1:0]   ilck_i,
    input  logic [NPORT*NVCH-1:0]   irdy_i,
    input  logic [NPORT-1:0]        grt_i,
    output logic                    req_o,
    output logic                    send_o,
    output logic                    olck_o,
    output logic [CNTW-1:0]         flits_o,
    output logic                    err_o,
    output logic                    tmo_o
);
    typedef enum logic [1:0] {RC = 2'b00, VA = 2'b01, ST = 2'b10} state_e;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    state_e                  state_q, state_d;
    logic [CNTW-1:0]         flits_q, flits_d;
    logic                    err_q, err_d;
    logic [NPORT*NVCH-1:0]   lck_sh, rdy_sh;
    logic [NPORT-1:0]        grt_sh;
    logic                    route_bad, sel_lck, sel_rdy, sel_grt;
    logic                    is_head, in_va, in_st, req_raw, req_c, send_c, tmo_hit;

    always_comb begin
        route_bad = (int'(port_i) >= NPORT) || (int'(ovch_i) >= NVCH);
        lck_sh    = ilck_i >> (int'(port_i) * NVCH + int'(ovch_i));
        rdy_sh    = irdy_i >> (int'(port_i) * NVCH + int'(ovch_i));
        grt_sh    = grt_i >> port_i;
        sel_lck   = ~route_bad & lck_sh[0];
        sel_rdy   = ~route_bad & rdy_sh[0];
        sel_grt   = ~route_bad & grt_sh[0];
        is_head   = btype_i[0];
        in_va     = (state_q == VA);
        in_st     = (state_q == ST);
        req_raw   = (in_va & bvalid_i & ~sel_lck) | (in_st & bvalid_i);
        req_c     = req_raw & ~tmo_hit;
        send_c    = req_c & sel_grt & sel_rdy;
    end

`ifdef VC_TIMEOUT_EN
    localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WAITW-1:0] wait_q, wait_d;
    logic             tmo_q;

    assign tmo_hit = (in_va | in_st) && (int'(wait_q) >= TIMEOUT);

    // Only an unbroken run of unanswered requests counts toward the timeout.
    always_comb begin
        wait_d = '0;
        if ((in_va | in_st) && req_c && !send_c)
            wait_d = WAITW'(wait_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_hit;
        end
    end

    assign tmo_o = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        flits_d = flits_q;
        err_d   = bvalid_i & route_bad;
        case (state_q)
            VA: begin
                if (send_c)
                    state_d = (btype_i == T_HT || btype_i == T_TAIL) ? RC : ST;
            end
            ST: begin
                if (bvalid_i && is_head)
                    err_d = 1'b1;
                if (send_c && btype_i == T_TAIL)
                    state_d = RC;
            end
            default: begin
                // The unused encoding behaves as RC so a corrupted state recovers on the next head.
                state_d = RC;
                if (bvalid_i) begin
                    if (is_head) begin
                        state_d = VA;
                        flits_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
        if (send_c && flits_q != '1)
            flits_d = flits_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RC;
            flits_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flits_q <= flits_d;
            err_q   <= err_d;
        end
    end

    assign req_o   = req_c;
    assign send_o  = send_c;
    assign olck_o  = in_va | in_st;
    assign flits_o = flits_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_vc_ctrl_param.sv
// Bench for vc_ctrl_param: directed packet scenarios with literal expectations, then randomized traffic
// checked every cycle against a packet-level model.
module tb_vc_ctrl_param;
    localparam int NPORT = 5;
    localparam int NVCH  = 2;
    localparam int PORTW = 3;
    localparam int VCHW  = 1;
    localparam int CNTW  = 3;
    localparam int TMO   = 4;
    localparam int NW    = NPORT * NVCH;
    localparam int FMAX  = (1 << CNTW) - 1;
    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;
    localparam logic [NW-1:0]    R5   = 10'b00_0010_0000;
    localparam logic [NPORT-1:0] G2   = 5'b00100;
    localparam logic [NW-1:0]    NONE = '0;
    localparam logic [NW-1:0]    ALLR = '1;
    localparam logic [NPORT-1:0] ALLG = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bvalid = 1'b0;
    logic [1:0]       btype = BODY;
    logic [PORTW-1:0] port = '0;
    logic [VCHW-1:0]  ovch = '0;
    logic [NW-1:0]    ilck = '0, irdy = '0;
    logic [NPORT-1:0] grt = '0;
    logic             req_o, send_o, olck_o, err_o, tmo_o;
    logic [CNTW-1:0]  flits_o;

    int  n_chk = 0, n_pass = 0;
    bit  m_in_pkt, m_alloc, m_err, m_tmo, m_last_send;
    int  m_flits, m_wait;

    vc_ctrl_param #(.NPORT(NPORT), .NVCH(NVCH), .PORTW(PORTW), .VCHW(VCHW),
                    .CNTW(CNTW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bvalid_i(bvalid), .btype_i(btype), .port_i(port),
        .ovch_i(ovch), .ilck_i(ilck), .irdy_i(irdy), .grt_i(grt), .req_o(req_o),
        .send_o(send_o), .olck_o(olck_o), .flits_o(flits_o), .err_o(err_o), .tmo_o(tmo_o));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Packet-level reference: tracks whether a packet is open, whether its output VC is won,
    // how many flits have left, and how long the open request has gone unanswered.
    always @(negedge clk) begin
        bit bad, lck, rdy, gt, htype, rq, sd, hit;
        int ix;
        logic [NW-1:0]    vl, vr;
        logic [NPORT-1:0] vg;
        if (!rst_n) begin
            m_in_pkt = 0; m_alloc = 0; m_err = 0; m_tmo = 0; m_last_send = 0;
            m_flits = 0; m_wait = 0;
        end else begin
            bad = (int'(port) >= NPORT) || (int'(ovch) >= NVCH);
            ix  = int'(port) * NVCH + int'(ovch);
            vl  = ilck >> ix;
            vr  = irdy >> ix;
            vg  = grt >> int'(port);
            lck = !bad && vl[0];
            rdy = !bad && vr[0];
            gt  = !bad && vg[0];
            htype = (btype == HEAD) || (btype == HT);
            hit = 0;
`ifdef VC_TIMEOUT_EN
            hit = m_in_pkt && (m_wait >= TMO);
`endif
            rq = m_in_pkt && bvalid && !hit && (m_alloc || !lck);
            sd = rq && gt && rdy;
            chk("req", int'(req_o), int'(rq));
            chk("send", int'(send_o), int'(sd));
            chk("olck", int'(olck_o), int'(m_in_pkt));
            chk("flits", int'(flits_o), m_flits);
            chk("err", int'(err_o), int'(m_err));
            chk("tmo", int'(tmo_o), int'(m_tmo));
            m_err  = bvalid && (bad || (!m_in_pkt && !htype) || (m_in_pkt && m_alloc && htype));
            m_tmo  = hit;
            m_wait = (m_in_pkt && rq && !sd) ? m_wait + 1 : 0;
            if (!m_in_pkt) begin
                if (bvalid && htype) begin
                    m_in_pkt = 1; m_alloc = 0; m_flits = 0;
                end
            end else if (sd) begin
                m_flits = (m_flits < FMAX) ? m_flits + 1 : FMAX;
                if (!m_alloc) begin
                    if (btype == HT || btype == TAIL) m_in_pkt = 0;
                    else m_alloc = 1;
                end else if (btype == TAIL) begin
                    m_in_pkt = 0;
                end
            end
            m_last_send = sd;
        end
    end

    task automatic apply(input bit bv, input logic [1:0] ty, input int pt, input int vc,
                         input logic [NW-1:0] lk, input logic [NW-1:0] rd, input logic [NPORT-1:0] gr);
        @(posedge clk);
        #1;
        bvalid = bv; btype = ty; port = PORTW'(pt); ovch = VCHW'(vc);
        ilck = lk; irdy = rd; grt = gr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        bvalid = 1'b0; ilck = '0; irdy = '0; grt = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1);
    end

    initial begin
        int len, idx, pp, vv;
        bit stray, bv;
        logic [1:0] ty;
        #1;
        chk("rst_req", int'(req_o), 0);
        chk("rst_olck", int'(olck_o), 0);
        chk("rst_flits", int'(flits_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_tmo", int'(tmo_o), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // HEAD, BODY, BODY, TAIL to port 2 / VC 1
        apply(1, HEAD, 2, 1, NONE, R5, G2); chk("p4_c0_send", int'(send_o), 0);
        chk("p4_c0_olck", int'(olck_o), 0);
        apply(1, HEAD, 2, 1, NONE, R5, G2); chk("p4_c1_send", int'(send_o), 1);
        chk("p4_c1_olck", int'(olck_o), 1);
        apply(1, BODY, 2, 1, NONE, R5, G2); chk("p4_c2_send", int'(send_o), 1);
        chk("p4_c2_flits", int'(flits_o), 1);
        apply(1, BODY, 2, 1, NONE, R5, G2); chk("p4_c3_flits", int'(flits_o), 2);
        apply(1, TAIL, 2, 1, NONE, R5, G2); chk("p4_c4_send", int'(send_o), 1);
        chk("p4_c4_flits", int'(flits_o), 3);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("p4_c5_olck", int'(olck_o), 0);
        chk("p4_c5_flits", int'(flits_o), 4);

        // HEADTAIL held off by a lock for cycles 0-3
        for (int c = 0; c < 4; c++) begin
            apply(1, HT, 2, 1, R5, R5, G2);
            chk("ht_lock_req", int'(req_o), 0);
        end
        apply(1, HT, 2, 1, NONE, R5, G2); chk("ht_c4_send", int'(send_o), 1);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("ht_c5_olck", int'(olck_o), 0);
        chk("ht_c5_flits", int'(flits_o), 1);

        // Ready stall inside ST
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        apply(1, BODY, 2, 1, NONE, NONE, G2); chk("stall_send", int'(send_o), 0);
        chk("stall_flits", int'(flits_o), 1);
        apply(1, BODY, 2, 1, NONE, R5, G2); chk("resume_send", int'(send_o), 1);
        chk("resume_flits", int'(flits_o), 1);
        apply(1, TAIL, 2, 1, NONE, R5, G2);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("stall_end_flits", int'(flits_o), 3);

        // Stray BODY in RC
        apply(1, BODY, 2, 1, NONE, R5, G2);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("stray_err", int'(err_o), 1);
        chk("stray_olck", int'(olck_o), 0);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("stray_err_end", int'(err_o), 0);

        // Flit counter saturation: 10 flits sent with a 3-bit counter
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        for (int c = 0; c < 8; c++) apply(1, BODY, 2, 1, NONE, R5, G2);
        apply(1, TAIL, 2, 1, NONE, R5, G2);
        apply(0, BODY, 2, 1, NONE, R5, G2); chk("sat_flits", int'(flits_o), 7);

        // Out-of-range port never gets a send
        apply(1, HEAD, 6, 0, NONE, ALLR, ALLG);
        for (int c = 0; c < 5; c++) begin
            apply(1, HEAD, 6, 0, NONE, ALLR, ALLG);
            chk("badport_send", int'(send_o), 0);
            chk("badport_err", int'(err_o), 1);
        end
        do_reset();

        // Timeout with no grant
        apply(1, HEAD, 2, 1, NONE, R5, '0);
        for (int c = 0; c < 4; c++) begin
            apply(1, HEAD, 2, 1, NONE, R5, '0);
            chk("tmo_wait_req", int'(req_o), 1);
        end
        apply(1, HEAD, 2, 1, NONE, R5, '0);
`ifdef VC_TIMEOUT_EN
        chk("tmo_drop_req", int'(req_o), 0);
        apply(1, HEAD, 2, 1, NONE, R5, '0);
        chk("tmo_pulse", int'(tmo_o), 1);
        chk("tmo_req_back", int'(req_o), 1);
`else
        chk("notmo_req", int'(req_o), 1);
        apply(1, HEAD, 2, 1, NONE, R5, '0);
        chk("notmo_tmo", int'(tmo_o), 0);
`endif
        do_reset();

        // Reset mid-ST with three flits sent
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        apply(1, HEAD, 2, 1, NONE, R5, G2);
        apply(1, BODY, 2, 1, NONE, R5, G2);
        apply(1, BODY, 2, 1, NONE, R5, G2);
        @(posedge clk);
        #1;
        chk("mid_flits", int'(flits_o), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", int'(req_o), 0);
        chk("mid_rst_send", int'(send_o), 0);
        chk("mid_rst_olck", int'(olck_o), 0);
        chk("mid_rst_flits", int'(flits_o), 0);
        bvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Randomized packet traffic; the buffer head advances only when a flit leaves
        len = 0; idx = 0; pp = 0; vv = 0; stray = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_last_send) idx++;
            if (idx >= len) begin
                if (!stray && $urandom_range(0, 7) == 0) begin
                    stray = 1;
                end else begin
                    stray = 0;
                    len = $urandom_range(1, 10);
                    idx = 0;
                    pp = $urandom_range(0, NPORT - 1);
                    vv = $urandom_range(0, NVCH - 1);
                end
            end
            if (stray)             ty = ($urandom_range(0, 1) == 0) ? BODY : TAIL;
            else if (len == 1)     ty = HT;
            else if (idx == 0)     ty = HEAD;
            else if (idx == len-1) ty = TAIL;
            else                   ty = ($urandom_range(0, 11) == 0) ? HEAD : BODY;
            bv = ($urandom_range(0, 3) != 0);
            apply(bv, ty, pp, vv, NW'($urandom & $urandom), NW'($urandom | $urandom),
                  NPORT'($urandom | $urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
